// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the memory-mapped peripheral bus.
// Serialises one transaction at a time with a fixed read-return latency.
module bus_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        grant,
  output logic [ADDR_W-1:0] bus_address,
  output logic [DATA_W-1:0] bus_write_data,
  output logic              bus_write_enable,
  output logic              bus_read_enable,
  input  logic [DATA_W-1:0] bus_read_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t r_state;
  state_t w_state_nx;

  logic              r_last;
  logic              r_sel;
  logic              r_we;
  logic [2:0]        r_cnt;
  logic [1:0]        r_grant;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic              r_bus_we;
  logic              r_bus_re;
  logic              r_ack0;
  logic              r_ack1;
  logic [DATA_W-1:0] r_rd0;
  logic [DATA_W-1:0] r_rd1;

  logic              w_last_nx;
  logic              w_sel_nx;
  logic              w_we_nx;
  logic [2:0]        w_cnt_nx;
  logic [1:0]        w_grant_nx;
  logic [ADDR_W-1:0] w_addr_nx;
  logic [DATA_W-1:0] w_wdata_nx;
  logic              w_bwe_nx;
  logic              w_bre_nx;
  logic              w_ack0_nx;
  logic              w_ack1_nx;
  logic [DATA_W-1:0] w_rd0_nx;
  logic [DATA_W-1:0] w_rd1_nx;

  logic w_any;
  logic w_pick;

  assign w_any  = m0_req | m1_req;
  // On a tie the master that did not win last time takes the bus
  assign w_pick = (m0_req & m1_req) ? ~r_last : m1_req;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_sel       <= 1'b0;
      r_we        <= 1'b0;
      r_cnt       <= 3'd0;
      r_grant     <= 2'b00;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_we    <= 1'b0;
      r_bus_re    <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_rd0       <= '0;
      r_rd1       <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_last      <= w_last_nx;
      r_sel       <= w_sel_nx;
      r_we        <= w_we_nx;
      r_cnt       <= w_cnt_nx;
      r_grant     <= w_grant_nx;
      r_bus_addr  <= w_addr_nx;
      r_bus_wdata <= w_wdata_nx;
      r_bus_we    <= w_bwe_nx;
      r_bus_re    <= w_bre_nx;
      r_ack0      <= w_ack0_nx;
      r_ack1      <= w_ack1_nx;
      r_rd0       <= w_rd0_nx;
      r_rd1       <= w_rd1_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_state_nx = S_ACCESS;
      S_ACCESS: w_state_nx = r_we ? S_DONE : S_WAIT;
      S_WAIT:   if (r_cnt == 3'd1) w_state_nx = S_DONE;
      S_DONE:   w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_last_nx  = r_last;
    w_sel_nx   = r_sel;
    w_we_nx    = r_we;
    w_cnt_nx   = r_cnt;
    w_grant_nx = r_grant;
    w_addr_nx  = r_bus_addr;
    w_wdata_nx = r_bus_wdata;
    w_bwe_nx   = 1'b0;
    w_bre_nx   = 1'b0;
    w_ack0_nx  = 1'b0;
    w_ack1_nx  = 1'b0;
    w_rd0_nx   = r_rd0;
    w_rd1_nx   = r_rd1;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_sel_nx   = w_pick;
          w_last_nx  = w_pick;
          w_we_nx    = w_pick ? m1_we : m0_we;
          w_grant_nx = w_pick ? 2'b10 : 2'b01;
          w_addr_nx  = w_pick ? m1_addr : m0_addr;
          w_wdata_nx = w_pick ? m1_wdata : m0_wdata;
          w_bwe_nx   = w_we_nx;
          w_bre_nx   = ~w_we_nx;
        end
      end
      S_ACCESS: begin
        if (r_we) begin
          w_ack0_nx = ~r_sel;
          w_ack1_nx = r_sel;
        end else begin
          w_cnt_nx = LAT;
        end
      end
      S_WAIT: begin
        w_cnt_nx = r_cnt - 3'd1;
        // Last wait cycle is the one in which the slave data is valid
        if (r_cnt == 3'd1) begin
          w_ack0_nx = ~r_sel;
          w_ack1_nx = r_sel;
          if (r_sel) w_rd1_nx = bus_read_data;
          else       w_rd0_nx = bus_read_data;
        end
      end
      S_DONE: begin
        w_grant_nx = 2'b00;
      end
      default: begin
        w_grant_nx = 2'b00;
      end
    endcase
  end

  assign m0_ack           = r_ack0;
  assign m1_ack           = r_ack1;
  assign m0_rdata         = r_rd0;
  assign m1_rdata         = r_rd1;
  assign grant            = r_grant;
  assign bus_address      = r_bus_addr;
  assign bus_write_data   = r_bus_wdata;
  assign bus_write_enable = r_bus_we;
  assign bus_read_enable  = r_bus_re;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: latency, round-robin order,
// no pre-emption and reset abort, on READ_LATENCY 1 and 3 builds.
module tb_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        m0_req, m0_we, m0_ack;
  logic [63:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_ack;
  logic [63:0] m1_addr, m1_wdata, m1_rdata;
  logic [1:0]  grant;
  logic [63:0] bus_address, bus_write_data, bus_rd;
  logic        bus_we, bus_re;

  logic        d3_req, d3_we, d3_ack, d3_m0_ack;
  logic [63:0] d3_addr, d3_wdata, d3_rdata, d3_m0_rdata;
  logic [1:0]  d3_grant;
  logic [63:0] d3_ba, d3_bwd, d3_rd;
  logic        d3_bwe, d3_bre;

  logic [63:0] slv;
  logic        p1 = 1'b0;
  logic [2:0]  p3 = 3'b000;

  always @(posedge clk) begin
    p1 <= bus_re;
    p3 <= {p3[1:0], d3_bre};
  end

  assign bus_rd = p1    ? slv : 64'hDEAD_DEAD_DEAD_DEAD;
  assign d3_rd  = p3[2] ? slv : 64'hDEAD_DEAD_DEAD_DEAD;

  bus_arbiter #(.ADDR_W(64), .DATA_W(64), .READ_LATENCY(1)) u_dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .grant(grant), .bus_address(bus_address),
    .bus_write_data(bus_write_data), .bus_write_enable(bus_we),
    .bus_read_enable(bus_re), .bus_read_data(bus_rd)
  );

  bus_arbiter #(.ADDR_W(64), .DATA_W(64), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .m0_req(1'b0), .m0_we(1'b0), .m0_addr(64'h0),
    .m0_wdata(64'h0), .m0_ack(d3_m0_ack), .m0_rdata(d3_m0_rdata),
    .m1_req(d3_req), .m1_we(d3_we), .m1_addr(d3_addr),
    .m1_wdata(d3_wdata), .m1_ack(d3_ack), .m1_rdata(d3_rdata),
    .grant(d3_grant), .bus_address(d3_ba),
    .bus_write_data(d3_bwd), .bus_write_enable(d3_bwe),
    .bus_read_enable(d3_bre), .bus_read_data(d3_rd)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run(input bit m, input logic we, input logic [63:0] a,
                     input logic [63:0] d, input int lat,
                     input logic [63:0] exp_rd);
    int cyc, nwe, nre;
    logic done, oth;
    @(negedge clk);
    if (m) begin
      m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
    end
    cyc = 0; nwe = 0; nre = 0; done = 1'b0; oth = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      nwe += int'(bus_we);
      nre += int'(bus_re);
      if (cyc == 1) begin
        chk("grant", 64'(grant), m ? 64'd2 : 64'd1);
        chk("addr", bus_address, a);
        if (we) chk("wdata", bus_write_data, d);
      end
      if (m ? m0_ack : m1_ack) oth = 1'b1;
      done = m ? m1_ack : m0_ack;
    end
    chk("lat", 64'(cyc), 64'(lat));
    chk("we_cnt", 64'(nwe), we ? 64'd1 : 64'd0);
    chk("re_cnt", 64'(nre), we ? 64'd0 : 64'd1);
    chk("other_ack", 64'(oth), 64'd0);
    if (!we) chk("rdata", m ? m1_rdata : m0_rdata, exp_rd);
    if (m) m1_req = 1'b0;
    else   m0_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int cyc, n, nstb, nack;
    int ord [4];
    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    d3_req = 0; d3_we = 0; d3_addr = 64'h8000_0010; d3_wdata = 0;
    slv = 64'h0;

    // reset state and quiet idle
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_ack", 64'({m0_ack, m1_ack}), 64'd0);
    chk("rst_addr", bus_address, 64'd0);
    chk("rst_rdata", m1_rdata, 64'd0);
    nstb = 0;
    repeat (4) begin
      @(negedge clk);
      nstb += int'(bus_we) + int'(bus_re) + int'(grant != 2'b00);
    end
    chk("idle_quiet", 64'(nstb), 64'd0);

    // single write and reads, both latencies
    run(1'b0, 1'b1, 64'h8000_0000, 64'h41, 2, 64'h0);
    chk("wr_keeps_rdata", m0_rdata, 64'h0);
    slv = 64'h5A;
    run(1'b1, 1'b0, 64'h8000_0010, 64'h0, 3, 64'h5A);
    chk("m0_rdata_untouched", m0_rdata, 64'h0);
    run(1'b1, 1'b1, 64'h8000_0010, 64'h7, 2, 64'h0);
    chk("m1_rdata_held", m1_rdata, 64'h5A);

    @(negedge clk);
    d3_req = 1'b1;
    cyc = 0;
    while (!d3_ack && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("lat3", 64'(cyc), 64'd5);
    chk("rdata3", d3_rdata, 64'h5A);
    d3_req = 1'b0;

    // continuous contention alternates
    do_reset();
    @(negedge clk);
    slv = 64'h77;
    m0_req = 1; m0_we = 1; m0_addr = 64'h8000_0000; m0_wdata = 64'h11;
    m1_req = 1; m1_we = 0; m1_addr = 64'h8000_0010;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (m0_ack | m1_ack) begin
        ord[n] = int'(m1_ack);
        chk("ack_grant", 64'(grant), m1_ack ? 64'd2 : 64'd1);
        n++;
      end
    end
    m0_req = 0; m1_req = 0;
    chk("rr_count", 64'(n), 64'd4);
    chk("rr_0", 64'(ord[0]), 64'd0);
    chk("rr_1", 64'(ord[1]), 64'd1);
    chk("rr_2", 64'(ord[2]), 64'd0);
    chk("rr_3", 64'(ord[3]), 64'd1);
    chk("rr_rdata", m1_rdata, 64'h77);
    nack = 0;
    repeat (4) begin
      @(negedge clk);
      nack += int'(m0_ack) + int'(m1_ack);
    end
    chk("rr_no_extra", 64'(nack), 64'd0);

    // late request waits for the running read
    @(negedge clk);
    slv = 64'h33;
    m0_req = 1; m0_we = 0; m0_addr = 64'h8000_0000;
    @(negedge clk);
    chk("np_grant0", 64'(grant), 64'd1);
    chk("np_re", 64'(bus_re), 64'd1);
    @(negedge clk);
    m1_req = 1; m1_we = 1; m1_addr = 64'h8000_0010; m1_wdata = 64'h99;
    @(negedge clk);
    chk("np_ack0", 64'(m0_ack), 64'd1);
    chk("np_grant_done", 64'(grant), 64'd1);
    chk("np_rdata0", m0_rdata, 64'h33);
    m0_req = 0;
    @(negedge clk);
    chk("np_idle", 64'(grant), 64'd0);
    @(negedge clk);
    chk("np_grant1", 64'(grant), 64'd2);
    chk("np_we", 64'(bus_we), 64'd1);
    chk("np_wdata", bus_write_data, 64'h99);
    @(negedge clk);
    chk("np_ack1", 64'(m1_ack), 64'd1);
    m1_req = 0;

    // reset during WAIT aborts silently
    @(negedge clk);
    slv = 64'h44;
    m0_req = 1; m0_we = 0; m0_addr = 64'h8000_0000;
    @(negedge clk);
    chk("ab_re", 64'(bus_re), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ab_ack", 64'({m0_ack, m1_ack}), 64'd0);
    chk("ab_grant", 64'(grant), 64'd0);
    chk("ab_strobe", 64'({bus_we, bus_re}), 64'd0);
    reset = 1'b1;
    m0_req = 0;
    nack = 0;
    repeat (3) begin
      @(negedge clk);
      nack += int'(m0_ack) + int'(m1_ack) + int'(bus_re);
    end
    chk("ab_quiet", 64'(nack), 64'd0);
    chk("ab_rdata", m0_rdata, 64'h0);
    run(1'b0, 1'b0, 64'h8000_0000, 64'h0, 3, 64'h44);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
